// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared register-address width, FSM encoding,
// default divide latency and the load-use compare helper.
// Optional feature macro used by the top: PIPE_CTRL_PERF_EN.
`ifndef RegAddrWidth
`define RegAddrWidth 5
`endif
`ifndef PipeCtrlStateWidth
`define PipeCtrlStateWidth 1
`endif
`ifndef PIPE_RUN
`define PIPE_RUN 1'b0
`endif
`ifndef PIPE_DIV_BUSY
`define PIPE_DIV_BUSY 1'b1
`endif
`ifndef DIV_CYCLES
`define DIV_CYCLES 8
`endif

package pipeline_hazard_ctrl_pkg;

  typedef enum logic [`PipeCtrlStateWidth-1:0] {
    ST_RUN      = `PIPE_RUN,
    ST_DIV_BUSY = `PIPE_DIV_BUSY
  } pipe_state_t;

  localparam int DEFAULT_DIV_CYCLES = `DIV_CYCLES;
  localparam int DEFAULT_CNT_WIDTH  = 8;

  // A load in EX feeds a source of the instruction in ID; r0 never hazards.
  function automatic logic load_use_hit(
    input logic                     read_mem,
    input logic [`RegAddrWidth-1:0] rt,
    input logic [`RegAddrWidth-1:0] rs1,
    input logic [`RegAddrWidth-1:0] rs2
  );
    return read_mem && (rt != '0) && ((rt == rs1) || (rt == rs2));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_div_latency_timer.sv
// div_latency_timer: countdown for the cycles a divide still owns EX.
// load preloads the count, running decrements it, zero flags expiry.
module div_latency_timer #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 running,
  output logic                 zero
);

  logic [CNT_WIDTH-1:0] cnt;

  // Load has priority; decrement stops at zero so the count never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (running && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Handles load-use stalls, taken-branch flushes and multi-cycle divides.
// Define PIPE_CTRL_PERF_EN to add saturating stall/flush counters.
`ifndef RegAddrWidth
`define RegAddrWidth 5
`endif

module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ReadMem_EX,
  input  logic [`RegAddrWidth-1:0] rt_EX,
  input  logic [`RegAddrWidth-1:0] raddr_1_ID,
  input  logic [`RegAddrWidth-1:0] raddr_2_ID,
  input  logic                     branch_taken_ID,
  input  logic                     div_start_EX,
  output logic                     hold_PC,
  output logic                     hold_IF_ID,
  output logic                     hold_ID_EX,
  output logic                     flush_IF_ID,
  output logic                     bubble_ID_EX,
  output logic                     bubble_EX_MEM,
  output logic                     div_done_EX,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0]              stall_cycles,
  output logic [31:0]              flush_count,
`endif
  output logic                     busy
);

  // Entry cycle is one stall, so the timer covers the remaining DIV_CYCLES-2
  // stalls before the completion cycle.
  localparam logic [CNT_WIDTH-1:0] LOAD_VAL = CNT_WIDTH'(DIV_CYCLES - 2);

  pipe_state_t state, state_next;
  logic        timer_load;
  logic        timer_run;
  logic        timer_zero;
  logic        lu_hit;

  div_latency_timer #(.CNT_WIDTH(CNT_WIDTH)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (LOAD_VAL),
    .running  (timer_run),
    .zero     (timer_zero)
  );

  assign lu_hit = load_use_hit(ReadMem_EX, rt_EX, raddr_1_ID, raddr_2_ID);

  // State register; reset parks the sequencer in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and all controls; everything is forced low while rst is high.
  always_comb begin
    state_next    = state;
    timer_load    = 1'b0;
    timer_run     = 1'b0;
    hold_PC       = 1'b0;
    hold_IF_ID    = 1'b0;
    hold_ID_EX    = 1'b0;
    flush_IF_ID   = 1'b0;
    bubble_ID_EX  = 1'b0;
    bubble_EX_MEM = 1'b0;
    div_done_EX   = 1'b0;
    busy          = 1'b0;
    if (!rst) begin
      case (state)
        ST_RUN: begin
          if (div_start_EX) begin
            hold_PC       = 1'b1;
            hold_IF_ID    = 1'b1;
            hold_ID_EX    = 1'b1;
            bubble_EX_MEM = 1'b1;
            timer_load    = 1'b1;
            state_next    = ST_DIV_BUSY;
          end else if (lu_hit) begin
            hold_PC      = 1'b1;
            hold_IF_ID   = 1'b1;
            bubble_ID_EX = 1'b1;
          end else if (branch_taken_ID) begin
            flush_IF_ID = 1'b1;
          end
        end
        ST_DIV_BUSY: begin
          busy = 1'b1;
          if (!timer_zero) begin
            hold_PC       = 1'b1;
            hold_IF_ID    = 1'b1;
            hold_ID_EX    = 1'b1;
            bubble_EX_MEM = 1'b1;
            timer_run     = 1'b1;
          end else begin
            div_done_EX = 1'b1;
            state_next  = ST_RUN;
          end
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Saturating counts of PC-hold cycles and IF_ID flush cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (hold_PC && (stall_cycles != 32'hFFFF_FFFF)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush_IF_ID && (flush_count != 32'hFFFF_FFFF)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table-driven and sequence checks of the
// hazard sequencer, with DIV_CYCLES=8 and DIV_CYCLES=2 instances.
`ifndef RegAddrWidth
`define RegAddrWidth 5
`endif

module tb_pipeline_hazard_ctrl;

  localparam int AW = `RegAddrWidth;

  // Output vector bit weights: {hPC,hIFID,hIDEX,flush,bIDEX,bEXMEM,done,busy}
  localparam logic [7:0] O_NONE  = 8'h00;
  localparam logic [7:0] O_FLUSH = 8'h10;
  localparam logic [7:0] O_STALL = 8'hC8;
  localparam logic [7:0] O_DIVE  = 8'hE4;
  localparam logic [7:0] O_DIVB  = 8'hE5;
  localparam logic [7:0] O_DONE  = 8'h03;

  typedef struct {
    string          name;
    logic           rd;
    logic [AW-1:0]  rt;
    logic [AW-1:0]  r1;
    logic [AW-1:0]  r2;
    logic           br;
    logic           dv;
    logic           dv2;
    logic [7:0]     exp1;
    logic [7:0]     exp2;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp1;
    logic [7:0] exp2;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          ReadMem_EX;
  logic [AW-1:0] rt_EX, raddr_1_ID, raddr_2_ID;
  logic          branch_taken_ID, div_start_EX;
  logic          div_start2;
  logic          zbit = 1'b0;
  logic [AW-1:0] zaddr = '0;

  logic h_pc1, h_ifid1, h_idex1, fl1, b_idex1, b_exmem1, done1, busy1;
  logic h_pc2, h_ifid2, h_idex2, fl2, b_idex2, b_exmem2, done2, busy2;
  logic [7:0] out1, out2;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall1, flushc1, stall2, flushc2;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;
  exp_t sb[$];
  vec_t tbl[11];

  always #5 clk = ~clk;

  assign out1 = {h_pc1, h_ifid1, h_idex1, fl1, b_idex1, b_exmem1, done1, busy1};
  assign out2 = {h_pc2, h_ifid2, h_idex2, fl2, b_idex2, b_exmem2, done2, busy2};

  pipeline_hazard_ctrl #(.DIV_CYCLES(8), .CNT_WIDTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .ReadMem_EX      (ReadMem_EX),
    .rt_EX           (rt_EX),
    .raddr_1_ID      (raddr_1_ID),
    .raddr_2_ID      (raddr_2_ID),
    .branch_taken_ID (branch_taken_ID),
    .div_start_EX    (div_start_EX),
    .hold_PC         (h_pc1),
    .hold_IF_ID      (h_ifid1),
    .hold_ID_EX      (h_idex1),
    .flush_IF_ID     (fl1),
    .bubble_ID_EX    (b_idex1),
    .bubble_EX_MEM   (b_exmem1),
    .div_done_EX     (done1),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cycles    (stall1),
    .flush_count     (flushc1),
`endif
    .busy            (busy1)
  );

  pipeline_hazard_ctrl #(.DIV_CYCLES(2), .CNT_WIDTH(8)) dut2 (
    .clk             (clk),
    .rst             (rst),
    .ReadMem_EX      (zbit),
    .rt_EX           (zaddr),
    .raddr_1_ID      (zaddr),
    .raddr_2_ID      (zaddr),
    .branch_taken_ID (zbit),
    .div_start_EX    (div_start2),
    .hold_PC         (h_pc2),
    .hold_IF_ID      (h_ifid2),
    .hold_ID_EX      (h_idex2),
    .flush_IF_ID     (fl2),
    .bubble_ID_EX    (b_idex2),
    .bubble_EX_MEM   (b_exmem2),
    .div_done_EX     (done2),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cycles    (stall2),
    .flush_count     (flushc2),
`endif
    .busy            (busy2)
  );

  function automatic vec_t mk(input string name, input logic rd, input int rt,
                              input int r1, input int r2, input logic br,
                              input logic dv, input logic dv2,
                              input logic [7:0] e1, input logic [7:0] e2);
    vec_t v;
    v.name = name; v.rd = rd;
    v.rt = AW'(rt); v.r1 = AW'(r1); v.r2 = AW'(r2);
    v.br = br; v.dv = dv; v.dv2 = dv2; v.exp1 = e1; v.exp2 = e2;
    return v;
  endfunction

  task automatic pushExp(input string name, input logic [7:0] e1, input logic [7:0] e2);
    exp_t e;
    e.name = name; e.exp1 = e1; e.exp2 = e2;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input vec_t v);
    ReadMem_EX      = v.rd;
    rt_EX           = v.rt;
    raddr_1_ID      = v.r1;
    raddr_2_ID      = v.r2;
    branch_taken_ID = v.br;
    div_start_EX    = v.dv;
    div_start2      = v.dv2;
    pushExp(v.name, v.exp1, v.exp2);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      n_compared++; n_mismatched++;
      $display("[TB] FAIL scoreboard: got empty queue, want an entry");
      return;
    end
    e = sb.pop_front();
    n_compared++;
    if (out1 !== e.exp1) begin
      n_mismatched++;
      $display("[TB] FAIL %s (div8): got %b want %b", e.name, out1, e.exp1);
    end
    n_compared++;
    if (out2 !== e.exp2) begin
      n_mismatched++;
      $display("[TB] FAIL %s (div2): got %b want %b", e.name, out2, e.exp2);
    end
    n_compared++;
    if ((h_idex1 & b_idex1) !== 1'b0 || (h_idex2 & b_idex2) !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL %s mutex: got hold_ID_EX&bubble_ID_EX=1 want 0", e.name);
    end
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic checkPerf(input string name, input logic [31:0] es, input logic [31:0] ef);
    n_compared++;
    if (stall1 !== es || flushc1 !== ef) begin
      n_mismatched++;
      $display("[TB] FAIL %s perf: got stall=%0d flush=%0d want stall=%0d flush=%0d",
               name, stall1, flushc1, es, ef);
    end
  endtask
`endif

  task automatic runVec(input vec_t v);
    @(posedge clk);
    #1;
    applyStimulus(v);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    tbl[0]  = mk("idle",          0, 0, 0, 0, 0, 0, 0, O_NONE,  O_NONE);
    tbl[1]  = mk("lu_rs1",        1, 5, 5, 0, 0, 0, 0, O_STALL, O_NONE);
    tbl[2]  = mk("lu_released",   0, 5, 5, 0, 0, 0, 0, O_NONE,  O_NONE);
    tbl[3]  = mk("lu_rs2",        1, 5, 3, 5, 0, 0, 0, O_STALL, O_NONE);
    tbl[4]  = mk("lu_rt0",        1, 0, 0, 0, 0, 0, 0, O_NONE,  O_NONE);
    tbl[5]  = mk("lu_nomatch",    1, 5, 4, 6, 0, 0, 0, O_NONE,  O_NONE);
    tbl[6]  = mk("br_alone",      0, 0, 0, 0, 1, 0, 0, O_FLUSH, O_NONE);
    tbl[7]  = mk("br_vs_lu",      1, 9, 2, 9, 1, 0, 0, O_STALL, O_NONE);
    tbl[8]  = mk("br_reresolve",  0, 0, 2, 9, 1, 0, 0, O_FLUSH, O_NONE);
    tbl[9]  = mk("lu_r31",        1, 31, 31, 31, 0, 0, 0, O_STALL, O_NONE);
    tbl[10] = mk("br_rt0_load",   1, 0, 0, 0, 1, 0, 0, O_FLUSH, O_NONE);

    // Reset with every input asserting something: outputs must stay low.
    rst = 1'b1;
    ReadMem_EX = 1'b1; rt_EX = AW'(5); raddr_1_ID = AW'(5); raddr_2_ID = '0;
    branch_taken_ID = 1'b1; div_start_EX = 1'b1; div_start2 = 1'b1;
    #2;
    pushExp("reset_t0", O_NONE, O_NONE);
    checkOutput();
    @(negedge clk);
    pushExp("reset_held", O_NONE, O_NONE);
    checkOutput();
`ifdef PIPE_CTRL_PERF_EN
    checkPerf("reset", 32'd0, 32'd0);
`endif
    applyStimulus(tbl[0]);
    rst = 1'b0;
    #1;
    checkOutput();

    foreach (tbl[i]) runVec(tbl[i]);

    // DIV_CYCLES=8 divide with branch/hazard noise; DIV_CYCLES=2 back-to-back.
    for (int i = 1; i <= 9; i++) begin
      vec_t v;
      logic [7:0] e1, e2;
      e1 = (i == 1) ? O_DIVE : (i <= 7) ? O_DIVB : (i == 8) ? O_DONE : O_NONE;
      e2 = (i == 1 || i == 3) ? O_DIVE : (i == 2 || i == 4) ? O_DONE : O_NONE;
      v = mk($sformatf("div_c%0d", i), (i == 6), 7, 7, 0, (i >= 3 && i <= 5),
             (i <= 8), (i <= 4), e1, e2);
      runVec(v);
    end

    // Asynchronous reset in the third cycle of a divide.
    runVec(mk("rdiv_c1", 0, 0, 0, 0, 0, 1, 1, O_DIVE, O_DIVE));
    runVec(mk("rdiv_c2", 0, 0, 0, 0, 1, 1, 1, O_DIVB, O_DONE));
    runVec(mk("rdiv_c3", 1, 4, 4, 0, 1, 1, 1, O_DIVB, O_DIVE));
    #1;
    rst = 1'b1;
    #1;
    pushExp("async_reset", O_NONE, O_NONE);
    checkOutput();
    @(negedge clk);
    pushExp("reset_mid_hold", O_NONE, O_NONE);
    checkOutput();
    applyStimulus(tbl[0]);
    rst = 1'b0;
    #1;
    checkOutput();
    runVec(mk("post_rst_run", 0, 0, 0, 0, 0, 0, 0, O_NONE, O_NONE));
    runVec(mk("post_rst_br", 0, 0, 0, 0, 1, 0, 0, O_FLUSH, O_NONE));
    runVec(mk("post_rst_lu", 1, 3, 0, 3, 0, 0, 0, O_STALL, O_NONE));

    // Counter scenario: one divide, one load-use stall, two taken branches.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      runVec(mk($sformatf("perf_div_c%0d", i), 0, 0, 0, 0, 0, 1, 0,
                (i == 1) ? O_DIVE : (i <= 7) ? O_DIVB : O_DONE, O_NONE));
    end
    runVec(mk("perf_idle0", 0, 0, 0, 0, 0, 0, 0, O_NONE, O_NONE));
    runVec(mk("perf_lu", 1, 12, 12, 1, 0, 0, 0, O_STALL, O_NONE));
    runVec(mk("perf_br1", 0, 0, 0, 0, 1, 0, 0, O_FLUSH, O_NONE));
    runVec(mk("perf_br2", 0, 0, 0, 0, 1, 0, 0, O_FLUSH, O_NONE));
    runVec(mk("perf_idle1", 0, 0, 0, 0, 0, 0, 0, O_NONE, O_NONE));
`ifdef PIPE_CTRL_PERF_EN
    checkPerf("perf_totals", 32'd8, 32'd2);
`endif

    if (sb.size() != 0) begin
      n_compared++; n_mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the hold and bubble controls of PC, IF_ID, ID_EX and EX_MEM.
- Detects load-use hazards and taken-branch redirects.
- Freezes the front of the pipeline while a multi-cycle divide occupies EX.
- Sits beside the decoder; all outputs are consumed by the stage registers and the PC unit in the same cycle.

Parameters:
- DIV_CYCLES, 8, total cycles a DIV/DIVU instruction occupies EX; legal range 2..255.
- CNT_WIDTH, 8, width of the divide countdown register.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous reset, active-high
- ReadMem_EX  input  1  instruction in EX is a load
- rt_EX  input  `RegAddrWidth  load destination register in EX
- raddr_1_ID  input  `RegAddrWidth  source register 1 of instruction in ID
- raddr_2_ID  input  `RegAddrWidth  source register 2 of instruction in ID
- branch_taken_ID  input  1  branch/jump in ID resolved as taken
- div_start_EX  input  1  instruction in EX is DIV/DIVU
- hold_PC  output  1  PC keeps its value
- hold_IF_ID  output  1  IF_ID keeps its value
- hold_ID_EX  output  1  ID_EX keeps its value
- flush_IF_ID  output  1  IF_ID loads a bubble
- bubble_ID_EX  output  1  ID_EX loads a bubble (all controls 0)
- bubble_EX_MEM  output  1  EX_MEM loads a bubble
- div_done_EX  output  1  divide result valid this cycle
- busy  output  1  FSM is in DIV_BUSY

Behaviour:
State and reset
- States: RUN, DIV_BUSY. A CNT_WIDTH countdown register `cnt`.
- rst (async, any time, including mid-divide): state=RUN, cnt=0.
- While rst is high, every output is 0.
- All outputs are combinational from state, cnt and the current inputs; zero-cycle latency.

Load-use hazard
- Condition: RUN && ReadMem_EX && rt_EX!=0 && (rt_EX==raddr_1_ID || rt_EX==raddr_2_ID).
- Response: hold_PC=1, hold_IF_ID=1, bubble_ID_EX=1, for exactly one cycle.
- The condition clears by itself once the bubble reaches EX.

Taken branch
- Condition: RUN && branch_taken_ID && no load-use hazard.
- Response: flush_IF_ID=1 for one cycle.
- If a load-use hazard and a taken branch coincide, the load-use response wins and flush_IF_ID=0. The branch re-resolves next cycle.

Divide sequencing
- Entry cycle: in RUN with div_start_EX=1, div takes priority over load-use and branch (they cannot co-occur in EX anyway).
  - Assert hold_PC, hold_IF_ID, hold_ID_EX and bubble_EX_MEM.
  - Next state DIV_BUSY with cnt=DIV_CYCLES-2.
- DIV_BUSY with cnt>0:
  - Same four outputs asserted.
  - cnt decrements.
  - div_start_EX, branch_taken_ID and the hazard inputs are ignored.
- DIV_BUSY with cnt==0:
  - div_done_EX=1; all holds and bubbles are 0, so the pipeline advances.
  - Next state RUN.
- Net effect: the divide occupies EX for exactly DIV_CYCLES cycles, with DIV_CYCLES-1 stall cycles.
- busy=1 in every DIV_BUSY cycle.
- A back-to-back divide is re-detected on the first RUN cycle after the previous div_done_EX.

Mutual exclusion
- hold_ID_EX and bubble_ID_EX are never both 1.

Optional Feature:
Macro `PIPE_CTRL_PERF_EN`.
- Defined:
  - Adds outputs stall_cycles[31:0] and flush_count[31:0], both reset to 0 by rst.
  - stall_cycles increments in every cycle hold_PC=1.
  - flush_count increments in every cycle flush_IF_ID=1.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared define file:
  - `RegAddrWidth (already present).
  - `PipeCtrlStateWidth (1).
  - `PIPE_RUN=1'b0, `PIPE_DIV_BUSY=1'b1.
  - Default `DIV_CYCLES.
- One natural sub-module: div_latency_timer, containing the cnt register plus load/decrement/zero-detect. Its ports are clk, rst, load, load_val, running, zero.

Test Plan:
- Load-use: lw with rt_EX=5, raddr_1_ID=5 -> exactly one cycle of hold_PC=hold_IF_ID=bubble_ID_EX=1. Same stimulus with rt_EX=0 -> no stall.
- Branch vs hazard: branch_taken_ID=1 alone -> flush_IF_ID=1 for one cycle. Together with a load-use match -> flush_IF_ID=0, stall asserted, and the next cycle branch_taken_ID=1 gives flush_IF_ID=1.
- Divide, DIV_CYCLES=8: div_start_EX held high -> holds and bubble_EX_MEM high 7 cycles, then div_done_EX=1 on cycle 8 with holds low, then RUN. Inject branch_taken_ID during busy -> no flush.
- Back-to-back divides, DIV_CYCLES=2: two consecutive DIVs -> pattern hold, done, hold, done.
- Reset mid-divide: assert rst at cycle 3 of a divide -> all outputs 0 immediately (asynchronous). After release, state is RUN and busy=0.
- With `PIPE_CTRL_PERF_EN`: one divide (DIV_CYCLES=8) plus one load-use stall plus two taken branches -> stall_cycles=8, flush_count=2.
